// File: rtl/stump_seq_alu_if.sv
// stump_seq_alu_if
//   Bundles the request and response signals between the Stump datapath
//   control and the sequential ALU.
//   master : drives start, func, operand_A, operand_B, c_in, csh
//            and observes busy, done, result, flags_out, flags_we
//   slave  : the ALU side (mirror of master)
//   Parameter WIDTH sets the operand/result width (4..32).
interface stump_seq_alu_if #(parameter int WIDTH = 16);
   logic             start;
   logic [2:0]       func;
   logic [WIDTH-1:0] operand_A;
   logic [WIDTH-1:0] operand_B;
   logic             c_in;
   logic             csh;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags_out;
   logic             flags_we;

   modport master (
      output start, func, operand_A, operand_B, c_in, csh,
      input  busy, done, result, flags_out, flags_we
   );

   modport slave (
      input  start, func, operand_A, operand_B, c_in, csh,
      output busy, done, result, flags_out, flags_we
   );
endinterface

// File: rtl/stump_seq_alu.sv
// stump_seq_alu
//   Registered Stump ALU with a start/done handshake. Single-cycle ops
//   complete one edge after acceptance; the optional shift-and-add
//   multiplier (compiled in when STUMP_ALU_MUL_EN is defined) takes
//   WIDTH further edges and holds busy while it runs.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : stump_seq_alu_if.slave (start/func/operands/carries in,
//            busy/done/result/flags_out/flags_we out, all registered)
//   Flags are {N,Z,V,C}. func 110 is MUL with STUMP_ALU_MUL_EN, LDST otherwise.
module stump_seq_alu #(
   parameter int WIDTH = 16
) (
   input logic           clk,
   input logic           rst,
   stump_seq_alu_if.slave bus
);

   localparam logic [2:0] F_ADD = 3'b000;
   localparam logic [2:0] F_ADC = 3'b001;
   localparam logic [2:0] F_SUB = 3'b010;
   localparam logic [2:0] F_SBC = 3'b011;
   localparam logic [2:0] F_AND = 3'b100;
   localparam logic [2:0] F_OR  = 3'b101;
   localparam logic [2:0] F_F6  = 3'b110;
   localparam logic [2:0] F_BCC = 3'b111;

`ifdef STUMP_ALU_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   typedef enum logic [1:0] {S_IDLE = 2'b00, S_DONE = 2'b01, S_MUL = 2'b10} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'b00, S_DONE = 2'b01} state_t;
`endif

   // Packs {N,Z,V,C} for a result
   function automatic logic [3:0] nzvc(input logic [WIDTH-1:0] r, input logic v, input logic c);
      return {r[WIDTH-1], (r == {WIDTH{1'b0}}), v, c};
   endfunction

   state_t           state_r, state_nx;
   logic             done_r, done_nx;
   logic             busy_nx;
   logic [WIDTH-1:0] result_r;
   logic [3:0]       flags_r;
   logic             flags_we_r;

   logic             accept_s;
   logic             is_mul_s;
   logic [WIDTH-1:0] b_op_s;
   logic             cin_s;
   logic [WIDTH:0]   sum_s;
   logic             arith_v_s;
   logic [WIDTH-1:0] op_res_s;
   logic [3:0]       op_flags_s;
   logic             op_we_s;

   // Only IDLE and DONE can take a new request; MUL ignores start
   assign accept_s = bus.start && ((state_r == S_IDLE) || (state_r == S_DONE));

`ifdef STUMP_ALU_MUL_EN
   logic             busy_r;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] mq_r;
   logic [CW-1:0]    count_r;
   logic [WIDTH:0]   step_sum_s;
   logic [WIDTH-1:0] acc_step_s;
   logic [WIDTH-1:0] mq_step_s;
   logic [3:0]       mul_flags_s;
   logic             last_step_s;

   assign is_mul_s    = (bus.func == F_F6);
   assign last_step_s = (state_r == S_MUL) && (count_r == CNT_ONE);

   // One shift-add step: {acc,mq} holds the partial product, mq's LSB selects the add
   always_comb begin
      step_sum_s  = {1'b0, acc_r} + (mq_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
      acc_step_s  = step_sum_s[WIDTH:1];
      mq_step_s   = {step_sum_s[0], mq_r[WIDTH-1:1]};
      mul_flags_s = nzvc(mq_step_s, (acc_step_s != {WIDTH{1'b0}}), 1'b0);
   end

   // Multiplier operand latch, partial product and step counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_r <= {WIDTH{1'b0}};
         acc_r   <= {WIDTH{1'b0}};
         mq_r    <= {WIDTH{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (accept_s && is_mul_s) begin
         mcand_r <= bus.operand_A;
         acc_r   <= {WIDTH{1'b0}};
         mq_r    <= bus.operand_B;
         count_r <= CNT_INIT;
      end else if (state_r == S_MUL) begin
         acc_r   <= acc_step_s;
         mq_r    <= mq_step_s;
         count_r <= count_r - CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign bus.busy = busy_r;
`else
   assign is_mul_s = 1'b0;
   assign bus.busy = 1'b0;
`endif

   // Adder operand/carry selection; B is inverted for the subtract forms
   always_comb begin
      b_op_s = bus.operand_B;
      cin_s  = 1'b0;
      case (bus.func)
         F_ADD:   begin b_op_s = bus.operand_B;  cin_s = 1'b0;     end
         F_ADC:   begin b_op_s = bus.operand_B;  cin_s = bus.c_in; end
         F_SUB:   begin b_op_s = ~bus.operand_B; cin_s = 1'b1;     end
         F_SBC:   begin b_op_s = ~bus.operand_B; cin_s = bus.c_in; end
         default: begin b_op_s = bus.operand_B;  cin_s = 1'b0;     end
      endcase
      sum_s     = {1'b0, bus.operand_A} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};
      arith_v_s = (bus.operand_A[WIDTH-1] == b_op_s[WIDTH-1]) &&
                  (sum_s[WIDTH-1] != bus.operand_A[WIDTH-1]);
   end

   // Single-cycle result/flags; pass-through ops re-present the held flags
   always_comb begin
      op_res_s   = bus.operand_B;
      op_flags_s = flags_r;
      op_we_s    = 1'b0;
      case (bus.func)
         F_ADD, F_ADC, F_SUB, F_SBC: begin
            op_res_s   = sum_s[WIDTH-1:0];
            op_flags_s = nzvc(sum_s[WIDTH-1:0], arith_v_s, sum_s[WIDTH]);
            op_we_s    = 1'b1;
         end
         F_AND: begin
            op_res_s   = bus.operand_A & bus.operand_B;
            op_flags_s = nzvc(bus.operand_A & bus.operand_B, 1'b0, bus.csh);
            op_we_s    = 1'b1;
         end
         F_OR: begin
            op_res_s   = bus.operand_A | bus.operand_B;
            op_flags_s = nzvc(bus.operand_A | bus.operand_B, 1'b0, bus.csh);
            op_we_s    = 1'b1;
         end
         F_F6:    op_res_s = bus.operand_B;
         F_BCC:   op_res_s = bus.operand_A;
         default: op_res_s = bus.operand_B;
      endcase
   end

   // State register plus registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         done_r  <= 1'b0;
`ifdef STUMP_ALU_MUL_EN
         busy_r  <= 1'b0;
`endif
      end else begin
         state_r <= state_nx;
         done_r  <= done_nx;
`ifdef STUMP_ALU_MUL_EN
         busy_r  <= busy_nx;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state_r;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_nx = is_mul_s ? state_t'(2'b10) : S_DONE;
            end else begin
               state_nx = S_IDLE;
            end
         end
`ifdef STUMP_ALU_MUL_EN
         S_MUL: begin
            if (count_r == CNT_ONE) begin
               state_nx = S_DONE;
            end else begin
               state_nx = S_MUL;
            end
         end
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the upcoming state, registered above
   always_comb begin
      done_nx = (state_nx == S_DONE);
      busy_nx = (state_nx != S_IDLE) && (state_nx != S_DONE);
   end

   // Result/flags registers change only on the edge that raises done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_r   <= {WIDTH{1'b0}};
         flags_r    <= 4'b0000;
         flags_we_r <= 1'b0;
      end else if (accept_s && !is_mul_s) begin
         result_r   <= op_res_s;
         flags_r    <= op_flags_s;
         flags_we_r <= op_we_s;
`ifdef STUMP_ALU_MUL_EN
      end else if (last_step_s) begin
         result_r   <= mq_step_s;
         flags_r    <= mul_flags_s;
         flags_we_r <= 1'b1;
`endif
      end else begin
         flags_we_r <= 1'b0;
      end
   end

   assign bus.done      = done_r;
   assign bus.result    = result_r;
   assign bus.flags_out = flags_r;
   assign bus.flags_we  = flags_we_r;

endmodule

// File: tb/tb_stump_seq_alu.sv
// tb_stump_seq_alu
//   Directed test-plan steps followed by randomized operations, each checked
//   against an arithmetic reference model (signed/unsigned integer maths).
//   Follows STUMP_ALU_MUL_EN to decide whether func 110 is MUL or LDST.
module tb_stump_seq_alu;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stump_seq_alu_if #(.WIDTH(W)) bus ();
   stump_seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_result;
   logic [3:0]   exp_flags;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values
   function automatic void ref_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic cs, input logic [3:0] old_fl,
                                  output logic [W-1:0] r, output logic [3:0] fl,
                                  output logic we, output bit is_mul);
      longint ua, ub, sa, sb, s, ss, brw;
      longint lim, smax, smin;
      logic v, c;
      lim  = longint'(1) << W;
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      v = 1'b0; c = 1'b0; we = 1'b1; is_mul = 1'b0; r = '0; s = 0;
      case (f)
         3'd0, 3'd1: begin
            brw = (f == 3'd1) ? longint'(ci) : 0;
            s  = ua + ub + brw;
            ss = sa + sb + brw;
            c  = (s >= lim);
            v  = (ss > smax) || (ss < smin);
            r  = s[W-1:0];
         end
         3'd2, 3'd3: begin
            brw = (f == 3'd2) ? 0 : longint'(!ci);
            s  = ua - ub - brw;
            ss = sa - sb - brw;
            c  = (s >= 0);
            v  = (ss > smax) || (ss < smin);
            r  = s[W-1:0];
         end
         3'd4: begin r = a & b; c = cs; end
         3'd5: begin r = a | b; c = cs; end
         3'd6: begin
`ifdef STUMP_ALU_MUL_EN
            s = ua * ub;
            r = s[W-1:0];
            v = (s >= lim);
            is_mul = 1'b1;
`else
            r  = b;
            we = 1'b0;
`endif
         end
         default: begin r = a; we = 1'b0; end
      endcase
      fl = we ? {r[W-1], (r == '0), v, c} : old_fl;
   endfunction

   // Issue one op at a negedge; return at the negedge where done is due
   task automatic do_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic cs, input string tag);
      logic [W-1:0] r;
      logic [3:0]   fl;
      logic         we;
      bit           m;
      ref_op(f, a, b, ci, cs, exp_flags, r, fl, we, m);
      bus.func = f; bus.operand_A = a; bus.operand_B = b; bus.c_in = ci; bus.csh = cs;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.func = 3'($urandom); bus.operand_A = W'($urandom); bus.operand_B = W'($urandom);
      bus.c_in = 1'($urandom); bus.csh = 1'($urandom);
      if (m) begin
         for (int i = 0; i < W; i++) begin
            chk({tag, "/busy"}, bus.busy, 32'd1);
            chk({tag, "/no_done"}, bus.done, 32'd0);
            chk({tag, "/held"}, bus.result, exp_result);
            bus.start = 1'b1; bus.func = 3'd0;
            bus.operand_A = W'($urandom); bus.operand_B = W'($urandom);
            @(negedge clk);
            bus.start = 1'b0;
         end
      end
      chk({tag, "/done"}, bus.done, 32'd1);
      chk({tag, "/busy0"}, bus.busy, 32'd0);
      chk({tag, "/result"}, bus.result, r);
      chk({tag, "/flags"}, bus.flags_out, fl);
      chk({tag, "/flags_we"}, bus.flags_we, we);
      exp_result = r;
      exp_flags  = fl;
   endtask

   // One cycle without start: done must drop, outputs held
   task automatic idle(input string tag);
      bus.start = 1'b0;
      @(negedge clk);
      chk({tag, "/idle_done"}, bus.done, 32'd0);
      chk({tag, "/idle_we"}, bus.flags_we, 32'd0);
      chk({tag, "/idle_res"}, bus.result, exp_result);
      chk({tag, "/idle_flags"}, bus.flags_out, exp_flags);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "/done"}, bus.done, 32'd0);
      chk({tag, "/busy"}, bus.busy, 32'd0);
      chk({tag, "/flags_we"}, bus.flags_we, 32'd0);
      chk({tag, "/result"}, bus.result, 32'd0);
      chk({tag, "/flags"}, bus.flags_out, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.func = 3'd0; bus.operand_A = '0; bus.operand_B = '0;
      bus.c_in = 1'b0; bus.csh = 1'b0;
      exp_result = '0;
      exp_flags  = 4'b0000;
      repeat (2) @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      do_op(3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
      chk("add_ovf/plan_res", bus.result, 32'h8000);
      chk("add_ovf/plan_flags", bus.flags_out, 32'hA);
      idle("add_ovf");

      do_op(3'd2, 16'h0005, 16'h0005, 1'b0, 1'b0, "sub_eq");
      chk("sub_eq/plan_flags", bus.flags_out, 32'h5);
      idle("sub_eq");

      do_op(3'd3, 16'h0000, 16'h0000, 1'b0, 1'b0, "sbc_zero");
      chk("sbc_zero/plan_res", bus.result, 32'hFFFF);
      chk("sbc_zero/plan_flags", bus.flags_out, 32'h8);
      idle("sbc_zero");

      do_op(3'd4, 16'hF0F0, 16'h0FF0, 1'b0, 1'b1, "and");
      chk("and/plan_res", bus.result, 32'h00F0);
      do_op(3'd7, 16'h1234, 16'h5555, 1'b0, 1'b0, "bcc");
      chk("bcc/plan_res", bus.result, 32'h1234);
      chk("bcc/plan_flags", bus.flags_out, 32'h1);
      idle("bcc");

`ifdef STUMP_ALU_MUL_EN
      do_op(3'd6, 16'h0100, 16'h0100, 1'b0, 1'b0, "mul");
      chk("mul/plan_flags", bus.flags_out, 32'h6);
`else
      do_op(3'd6, 16'h0000, 16'hBEEF, 1'b0, 1'b0, "ldst");
      chk("ldst/plan_res", bus.result, 32'hBEEF);
      chk("ldst/plan_we", bus.flags_we, 32'd0);
`endif
      idle("f6");

      do_op(3'd0, 16'h0001, 16'h0002, 1'b0, 1'b0, "b2b_1");
      do_op(3'd0, 16'h0003, 16'h0004, 1'b0, 1'b0, "b2b_2");
      chk("b2b_2/plan_res", bus.result, 32'h0007);
      idle("b2b");

      for (int n = 0; n < 60; n++) begin
         do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
               1'($urandom), 1'($urandom), "rand");
         if ($urandom_range(0, 1) == 1) idle("rand");
      end
      idle("rand_end");

`ifdef STUMP_ALU_MUL_EN
      bus.func = 3'd6; bus.operand_A = 16'h0003; bus.operand_B = 16'h0005;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
`else
      do_op(3'd0, 16'h1111, 16'h2222, 1'b0, 1'b0, "pre_rst");
`endif
      rst = 1'b1;
      #1;
      chk_reset_state("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      exp_result = '0;
      exp_flags  = 4'b0000;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         chk("post_rst/done", bus.done, 32'd0);
         chk("post_rst/busy", bus.busy, 32'd0);
      end
      chk_reset_state("post_rst");

      do_op(3'd1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, "adc_wrap");
      idle("adc_wrap");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
